// File: rtl/fcl_pkg.sv
// Shared types and default sizing for the fully-connected layer datapath.
package fcl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_POST  = 2'd2,
    ST_OUT   = 2'd3
  } fcl_state_e;

  localparam int FCL_IN_WIDTH   = 19;
  localparam int FCL_BEATS      = 24;
  localparam int FCL_NEURONS    = 84;
  localparam int FCL_BIAS_WIDTH = 16;
  localparam int FCL_ACC_WIDTH  = 32;
  localparam int FCL_SHIFT      = 8;
  localparam int FCL_OUT_WIDTH  = 8;

  // A single-neuron layer still needs a 1-bit index field.
  function automatic int fcl_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FCL_IDX_WIDTH = fcl_idx_width(FCL_NEURONS);

endpackage

// File: rtl/fcl_neuron_acc_if.sv
// Partial-sum input stream, result output stream and status for the neuron accumulator.
interface fcl_neuron_acc_if
  import fcl_pkg::*;
#(
  parameter int IN_WIDTH   = FCL_IN_WIDTH,
  parameter int BIAS_WIDTH = FCL_BIAS_WIDTH,
  parameter int OUT_WIDTH  = FCL_OUT_WIDTH,
  parameter int IDX_WIDTH  = FCL_IDX_WIDTH
);

  logic                  fcl_acc_flush_i;
  logic                  fcl_acc_in_valid_i;
  logic                  fcl_acc_in_ready_o;
  logic [IN_WIDTH-1:0]   fcl_acc_in_data_i;
  logic [BIAS_WIDTH-1:0] fcl_acc_bias_i;
  logic                  fcl_acc_out_valid_o;
  logic                  fcl_acc_out_ready_i;
  logic [OUT_WIDTH-1:0]  fcl_acc_out_data_o;
  logic [IDX_WIDTH-1:0]  fcl_acc_out_idx_o;
  logic                  fcl_acc_out_sat_o;
  logic                  fcl_acc_drop_err_o;

  modport master (
    output fcl_acc_flush_i,
    output fcl_acc_in_valid_i,
    input  fcl_acc_in_ready_o,
    output fcl_acc_in_data_i,
    output fcl_acc_bias_i,
    input  fcl_acc_out_valid_o,
    output fcl_acc_out_ready_i,
    input  fcl_acc_out_data_o,
    input  fcl_acc_out_idx_o,
    input  fcl_acc_out_sat_o,
    input  fcl_acc_drop_err_o
  );

  modport slave (
    input  fcl_acc_flush_i,
    input  fcl_acc_in_valid_i,
    output fcl_acc_in_ready_o,
    input  fcl_acc_in_data_i,
    input  fcl_acc_bias_i,
    output fcl_acc_out_valid_o,
    input  fcl_acc_out_ready_i,
    output fcl_acc_out_data_o,
    output fcl_acc_out_idx_o,
    output fcl_acc_out_sat_o,
    output fcl_acc_drop_err_o
  );

endinterface

// File: rtl/fcl_relu_shift_sat.sv
// ReLU, arithmetic right-shift requantisation and unsigned saturation of a signed accumulator.
module fcl_relu_shift_sat #(
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  logic signed [ACC_WIDTH-1:0] shifted_s;

  assign shifted_s = acc >>> SHIFT;

  // Negative sums clamp to zero; anything above the output range clips to all ones.
  always_comb begin
    data = {OUT_WIDTH{1'b0}};
    sat  = 1'b0;
    if (acc[ACC_WIDTH-1]) begin
      data = {OUT_WIDTH{1'b0}};
      sat  = 1'b0;
    end else if (shifted_s[ACC_WIDTH-1:OUT_WIDTH] != {(ACC_WIDTH-OUT_WIDTH){1'b0}}) begin
      data = {OUT_WIDTH{1'b1}};
      sat  = 1'b1;
    end else begin
      data = shifted_s[OUT_WIDTH-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/fcl_neuron_acc.sv
// Per-neuron accumulator: sums BEATS partial sums plus bias, requantises, and emits one tagged result.
module fcl_neuron_acc
  import fcl_pkg::*;
#(
  parameter int IN_WIDTH   = FCL_IN_WIDTH,
  parameter int BEATS      = FCL_BEATS,
  parameter int NEURONS    = FCL_NEURONS,
  parameter int BIAS_WIDTH = FCL_BIAS_WIDTH,
  parameter int ACC_WIDTH  = FCL_ACC_WIDTH,
  parameter int SHIFT      = FCL_SHIFT,
  parameter int OUT_WIDTH  = FCL_OUT_WIDTH
) (
  input logic             fcl_acc_clk,
  input logic             fcl_acc_rst,
  fcl_neuron_acc_if.slave bus
);

  localparam int IDX_W = fcl_idx_width(NEURONS);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);
  localparam fcl_state_e FIRST_NEXT = (BEATS == 1) ? ST_POST : ST_ACCUM;

  fcl_state_e                  state_r, state_next_s;
  logic [CNT_W-1:0]            cnt_r, cnt_next_s;
  logic [IDX_W-1:0]            idx_r, idx_next_s;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_next_s;
  logic                        out_valid_r, out_valid_next_s;
  logic [OUT_WIDTH-1:0]        out_data_r, out_data_next_s;
  logic                        out_sat_r, out_sat_next_s;
  logic [IDX_W-1:0]            out_idx_r, out_idx_next_s;
  logic                        drop_err_r, drop_err_next_s;

  logic                        in_ready_s;
  logic                        flush_abort_s;
  logic                        accept_s;
  logic                        drop_s;
  logic signed [ACC_WIDTH-1:0] bias_ext_s;
  logic signed [ACC_WIDTH-1:0] data_ext_s;
  logic [OUT_WIDTH-1:0]        post_data_s;
  logic                        post_sat_s;

  assign bias_ext_s = {{(ACC_WIDTH-BIAS_WIDTH){bus.fcl_acc_bias_i[BIAS_WIDTH-1]}}, bus.fcl_acc_bias_i};
  assign data_ext_s = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, bus.fcl_acc_in_data_i};

  fcl_relu_shift_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_post (
    .acc  (acc_r),
    .data (post_data_s),
    .sat  (post_sat_s)
  );

  // Input readiness per state; in OUT a new neuron may start only while the result drains.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready_s = 1'b1;
      ST_ACCUM: in_ready_s = 1'b1;
      ST_POST:  in_ready_s = 1'b0;
      ST_OUT:   in_ready_s = bus.fcl_acc_out_ready_i;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Flush cannot disturb a pending result, and a beat in an aborting cycle is simply ignored.
  assign flush_abort_s = bus.fcl_acc_flush_i && (state_r != ST_OUT);
  assign accept_s      = bus.fcl_acc_in_valid_i && in_ready_s && !flush_abort_s;
  assign drop_s        = bus.fcl_acc_in_valid_i && !in_ready_s && !flush_abort_s;

  // Next-state and datapath updates.
  always_comb begin
    state_next_s     = state_r;
    cnt_next_s       = cnt_r;
    idx_next_s       = idx_r;
    acc_next_s       = acc_r;
    out_valid_next_s = out_valid_r;
    out_data_next_s  = out_data_r;
    out_sat_next_s   = out_sat_r;
    out_idx_next_s   = out_idx_r;
    drop_err_next_s  = drop_err_r | drop_s;

    if (flush_abort_s) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = {CNT_W{1'b0}};
      acc_next_s   = {ACC_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            acc_next_s   = bias_ext_s + data_ext_s;
            cnt_next_s   = CNT_W'(1);
            state_next_s = FIRST_NEXT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            acc_next_s = acc_r + data_ext_s;
            cnt_next_s = cnt_r + CNT_W'(1);
            if ((cnt_r + CNT_W'(1)) == LAST_CNT) begin
              state_next_s = ST_POST;
            end else begin
              state_next_s = ST_ACCUM;
            end
          end else begin
            state_next_s = ST_ACCUM;
          end
        end
        ST_POST: begin
          out_data_next_s  = post_data_s;
          out_sat_next_s   = post_sat_s;
          out_idx_next_s   = idx_r;
          out_valid_next_s = 1'b1;
          cnt_next_s       = {CNT_W{1'b0}};
          state_next_s     = ST_OUT;
        end
        ST_OUT: begin
          if (bus.fcl_acc_out_ready_i) begin
            out_valid_next_s = 1'b0;
            if (idx_r == LAST_IDX) begin
              idx_next_s = {IDX_W{1'b0}};
            end else begin
              idx_next_s = idx_r + IDX_W'(1);
            end
            // A beat in the drain cycle is the first beat of the next neuron.
            if (accept_s) begin
              acc_next_s   = bias_ext_s + data_ext_s;
              cnt_next_s   = CNT_W'(1);
              state_next_s = FIRST_NEXT;
            end else begin
              cnt_next_s   = {CNT_W{1'b0}};
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_OUT;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          cnt_next_s   = {CNT_W{1'b0}};
          acc_next_s   = {ACC_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge fcl_acc_clk or posedge fcl_acc_rst) begin
    if (fcl_acc_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      acc_r       <= {ACC_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_sat_r   <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      drop_err_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      idx_r       <= idx_next_s;
      acc_r       <= acc_next_s;
      out_valid_r <= out_valid_next_s;
      out_data_r  <= out_data_next_s;
      out_sat_r   <= out_sat_next_s;
      out_idx_r   <= out_idx_next_s;
      drop_err_r  <= drop_err_next_s;
    end
  end

  assign bus.fcl_acc_in_ready_o  = in_ready_s;
  assign bus.fcl_acc_out_valid_o = out_valid_r;
  assign bus.fcl_acc_out_data_o  = out_data_r;
  assign bus.fcl_acc_out_idx_o   = out_idx_r;
  assign bus.fcl_acc_out_sat_o   = out_sat_r;
  assign bus.fcl_acc_drop_err_o  = drop_err_r;

endmodule

// File: tb/tb_fcl_neuron_acc.sv
// Directed self-checking bench for fcl_neuron_acc with hand-computed expected results.
module tb_fcl_neuron_acc;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fcl_neuron_acc_if bus ();

  fcl_neuron_acc dut (
    .fcl_acc_clk (clk),
    .fcl_acc_rst (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends count beats of val; bias first_bias on the first beat, junk afterwards.
  task automatic run_beats(input logic [18:0] val, input logic [15:0] first_bias, input int count);
    for (int i = 0; i < count; i++) begin
      bus.fcl_acc_in_valid_i = 1'b1;
      bus.fcl_acc_in_data_i  = val;
      bus.fcl_acc_bias_i     = (i == 0) ? first_bias : 16'sh7FFF;
      step();
    end
    bus.fcl_acc_in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.fcl_acc_out_valid_o && n < 40) begin
      step();
      n++;
    end
    check_value(tag, bus.fcl_acc_out_valid_o, 1);
  endtask

  task automatic consume();
    bus.fcl_acc_out_ready_i = 1'b1;
    step();
    bus.fcl_acc_out_ready_i = 1'b0;
    check_value("consume_valid_low", bus.fcl_acc_out_valid_o, 0);
  endtask

  task automatic check_result(input string tag, input int data, input int sat, input int idx);
    check_value({tag, "_data"}, bus.fcl_acc_out_data_o, 64'(data));
    check_value({tag, "_sat"}, bus.fcl_acc_out_sat_o, 64'(sat));
    check_value({tag, "_idx"}, bus.fcl_acc_out_idx_o, 64'(idx));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.fcl_acc_flush_i     = 1'b0;
    bus.fcl_acc_in_valid_i  = 1'b0;
    bus.fcl_acc_in_data_i   = 19'd0;
    bus.fcl_acc_bias_i      = 16'd0;
    bus.fcl_acc_out_ready_i = 1'b0;
    step();
    check_value("rst_out_valid", bus.fcl_acc_out_valid_o, 0);
    check_value("rst_out_data", bus.fcl_acc_out_data_o, 0);
    check_value("rst_out_sat", bus.fcl_acc_out_sat_o, 0);
    check_value("rst_drop_err", bus.fcl_acc_drop_err_o, 0);
    check_value("rst_in_ready", bus.fcl_acc_in_ready_o, 1);
    rst = 1'b0;
    step();

    // Flush after 10 beats, with a beat presented in the flush cycle.
    run_beats(19'd10, 16'sd16, 10);
    bus.fcl_acc_flush_i    = 1'b1;
    bus.fcl_acc_in_valid_i = 1'b1;
    step();
    bus.fcl_acc_flush_i    = 1'b0;
    bus.fcl_acc_in_valid_i = 1'b0;
    check_value("flush_in_ready", bus.fcl_acc_in_ready_o, 1);
    check_value("flush_drop_err", bus.fcl_acc_drop_err_o, 0);
    step();
    step();
    check_value("flush_no_output", bus.fcl_acc_out_valid_o, 0);

    // Basic neuron: 16 + 24*10 = 256 -> 1, with exact latency.
    run_beats(19'd10, 16'sd16, 24);
    check_value("lat_edge1_low", bus.fcl_acc_out_valid_o, 0);
    step();
    check_value("lat_edge2_high", bus.fcl_acc_out_valid_o, 1);
    check_result("basic", 1, 0, 0);

    // Backpressure hold, flush in OUT ignored.
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("hold_valid", bus.fcl_acc_out_valid_o, 1);
      check_value("hold_in_ready", bus.fcl_acc_in_ready_o, 0);
      check_result("hold", 1, 0, 0);
    end
    bus.fcl_acc_flush_i = 1'b1;
    step();
    bus.fcl_acc_flush_i = 1'b0;
    check_value("flush_in_out_valid", bus.fcl_acc_out_valid_o, 1);
    check_result("flush_in_out", 1, 0, 0);

    // Beat while in_ready is low is dropped.
    bus.fcl_acc_in_valid_i = 1'b1;
    bus.fcl_acc_in_data_i  = 19'd999;
    step();
    bus.fcl_acc_in_valid_i = 1'b0;
    check_value("drop_err_set", bus.fcl_acc_drop_err_o, 1);
    check_value("drop_valid_held", bus.fcl_acc_out_valid_o, 1);
    check_result("drop", 1, 0, 0);

    // out_ready with a beat: next neuron starts with bias 200 -> 200 + 24*4 = 296 -> 1.
    bus.fcl_acc_out_ready_i = 1'b1;
    bus.fcl_acc_in_valid_i  = 1'b1;
    bus.fcl_acc_in_data_i   = 19'd4;
    bus.fcl_acc_bias_i      = 16'sd200;
    step();
    bus.fcl_acc_out_ready_i = 1'b0;
    bus.fcl_acc_in_valid_i  = 1'b0;
    check_value("handover_valid_low", bus.fcl_acc_out_valid_o, 0);
    run_beats(19'd4, 16'sh7FFF, 23);
    wait_valid("handover_wait");
    check_result("handover", 1, 0, 1);
    consume();

    // Saturation: 24*524287 = 12582888 >> 8 = 49151 -> 255.
    run_beats(19'd524287, 16'sd0, 24);
    wait_valid("sat_wait");
    check_result("sat", 255, 1, 2);
    consume();

    // ReLU on negative and zero sums.
    run_beats(19'd0, -16'sd100, 24);
    wait_valid("relu_neg_wait");
    check_result("relu_neg", 0, 0, 3);
    consume();
    run_beats(19'd4, -16'sd96, 24);
    wait_valid("relu_zero_wait");
    check_result("relu_zero", 0, 0, 4);
    consume();

    // Truncation: 24000 - 1000 = 23000 >> 8 = 89.
    run_beats(19'd1000, -16'sd1000, 24);
    wait_valid("trunc_wait");
    check_result("trunc", 89, 0, 5);
    consume();

    for (int n = 6; n < 84; n++) begin
      run_beats(19'd0, 16'sd0, 24);
      wait_valid("sweep_wait");
      check_value("sweep_idx", bus.fcl_acc_out_idx_o, 64'(n));
      consume();
    end
    check_value("drop_err_sticky", bus.fcl_acc_drop_err_o, 1);

    run_beats(19'd10, 16'sd16, 24);
    wait_valid("wrap_wait");
    check_result("wrap", 1, 0, 0);

    // Drain with a new first beat, then reset mid-ACCUM.
    bus.fcl_acc_out_ready_i = 1'b1;
    bus.fcl_acc_in_valid_i  = 1'b1;
    bus.fcl_acc_in_data_i   = 19'd10;
    bus.fcl_acc_bias_i      = 16'sd16;
    step();
    bus.fcl_acc_out_ready_i = 1'b0;
    run_beats(19'd10, 16'sh7FFF, 3);
    bus.fcl_acc_in_valid_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_value("arst_out_valid", bus.fcl_acc_out_valid_o, 0);
    check_value("arst_out_data", bus.fcl_acc_out_data_o, 0);
    check_value("arst_drop_err", bus.fcl_acc_drop_err_o, 0);
    check_value("arst_in_ready", bus.fcl_acc_in_ready_o, 1);
    bus.fcl_acc_in_valid_i = 1'b0;
    step();
    rst = 1'b0;
    step();

    run_beats(19'd10, 16'sd16, 24);
    wait_valid("post_rst_wait");
    check_result("post_rst", 1, 0, 0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
